mo_line_buffer: RTL and testbench
=================================

# mo_line_buffer

Parametrised motion-object horizontal line buffer: the next-generation replacement for the fixed A/B ping-pong pair of counters plus 2149 RAMs. It holds NBUF rotating line buffers. During each scan line, one buffer accepts motion-object pixels streamed from the shifter, and another is read out to graphic priority control and cleared behind the beam. It also adds configurable overlap priority and write/read forwarding that the discrete version lacks.

## Interface
- XW, 9: pixel-address width; each buffer holds 2**XW pixels
- PW, 8: pixel width; value 0 is transparent
- NBUF, 2: number of rotating buffers, ≥2
- PRIO_MODE, 0: 0 = last non-transparent write wins; 1 = first non-transparent write wins, so a write lands only on a transparent cell
- clk  in  1  system clock
- reset_b  in  1  asynchronous, active-low reset
- swap  in  1  line-boundary pulse; rotates buffer roles
- wr_ld  in  1  load write counter from wr_x, which is where the next object starts
- wr_x  in  XW  object start X
- wr_valid  in  1  wr_pix is valid this cycle
- wr_pix  in  PW  object pixel
- rd_en  in  1  advance display side one pixel
- rd_pix  out  PW  display pixel (MPX equivalent)
- rd_valid  out  1  rd_pix is meaningful
- wr_buf  out  $clog2(NBUF)  index of the buffer being written
- rd_buf  out  $clog2(NBUF)  index of the buffer being displayed

## Operation
- **Reset values:**
  - wr_buf=0, rd_buf=NBUF-1.
  - Write counter = 0, read counter = 0.
  - rd_pix=0, rd_valid=0, primed=0.
  - Memory contents are not reset.
- **Swap:**
  - wr_buf ← (wr_buf+1) mod NBUF; rd_buf ← old wr_buf.
  - Read counter ← 0.
  - primed is set on the first swap after reset. While primed=0, rd_pix is forced to 0 and rd_valid stays 0.
- **Write side:**
  - wr_ld loads the write counter with wr_x.
  - If wr_valid is also high in the same cycle, the pixel goes to address wr_x and the counter becomes wr_x+1.
  - Otherwise each wr_valid writes at the counter, then the counter increments modulo 2**XW. It wraps from 2**XW-1 to 0, and the wrapped pixel is written.
  - Transparent pixels (0) never write but still advance the counter.
  - PRIO_MODE=1 performs read-modify-write: the write commits only if the stored cell is 0.
- **Display side:**
  - rd_en reads the read counter's address in rd_buf, writes 0 to that cell (clear-behind-read), then increments the counter modulo 2**XW.
  - rd_valid=1 is presented one cycle after an rd_en, when primed.
- **Forwarding (PRIO_MODE=1):** a write to the address written in the previous cycle must compare against the just-written value, not the stale RAM value. This happens when wr_ld retargets the previous address.
- **Simultaneous events:**
  - A wr_valid in the same cycle as swap writes to the pre-swap wr_buf.
  - An rd_en in the same cycle as swap reads the pre-swap rd_buf. The read counter becomes 0, not +1.
  - wr_ld takes precedence over the increment.
- **Mid-line reset:** reset_b assertion returns all state to reset values immediately. Partial line contents are don't-care.
- **Undefined:** behaviour for NBUF<2 is undefined; elaborate with a $error.

## Timing
- Write commit:
  - PRIO_MODE=0: one cycle after wr_valid.
  - PRIO_MODE=1: two cycles (read, compare/write).
  - Sustained throughput is one pixel per clock in both modes.
- Read latency: rd_pix is registered, one cycle after rd_en.
- swap takes effect on the clock edge where it is sampled. wr_buf and rd_buf update the same edge.
- The first pixel written after a swap is visible on the display side one swap later.

## Structure
- Package mo_lb_pkg:
  - TRANSPARENT constant.
  - Prio-mode enum {PRIO_LAST, PRIO_FIRST}.
  - Index-width helper function.
- Sub-module mo_lb_bank: one 2**XW×PW buffer with one synchronous read port and one write port.
  - Instantiated NBUF times.
  - Its ports are steered by role, so only one side uses a bank at a time.
- Top-level contents: role rotation, both counters, RMW pipeline with forwarding, clear-behind-read and output register.

## Test plan
- **Reset then swaps (NBUF=2):** reset, then two swaps.
  - After reset: wr_buf=0, rd_buf=1, rd_valid=0.
  - After the first swap: wr_buf=1, rd_buf=0.
  - After the second swap: wr_buf=0, rd_buf=1.
- **Basic write/read:** wr_ld with wr_x=10, pixels 5,0,7.
  - After swap, display reads 0,…,5 at x=10, 0 at x=11, 7 at x=12.
  - The next display of the same buffer returns all zeros (cleared).
- **Wrap:** XW=9, wr_x=510, four pixels 1,2,3,4 → cells 510,511,0,1 hold 1,2,3,4.
- **Overlap, PRIO_MODE=0 vs 1:** object A (pixel 3) at x=20 and object B (pixel 9) at x=20.
  - PRIO_MODE=0 reads 9; PRIO_MODE=1 reads 3.
  - With B retargeted via wr_ld to the immediately previous address, the forwarding path gives the same results.
- **Swap collision:** wr_valid and rd_en coincide with swap.
  - The pixel lands in the old write buffer.
  - The read returns the old rd_buf pixel.
  - The read counter restarts at 0.
- **NBUF=3 rotation and mid-line reset:**
  - Three swaps cycle wr_buf 0→1→2→0, with rd_buf trailing by one.
  - Asserting reset_b low mid-stream forces rd_valid=0 and wr_buf=0 at once.

Source files
------------

// File: rtl/mo_lb_pkg.sv
// Shared constants and types for the motion-object line buffer.
// Pixel value 0 is transparent; overlap priority is selected per instance.
package mo_lb_pkg;

  localparam int TRANSPARENT = 0;

  typedef enum logic {
    PRIO_LAST  = 1'b0,
    PRIO_FIRST = 1'b1
  } prio_e;

  // Buffer-index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mo_line_buffer_if.sv
// Shifter-side write stream, display-side read stream and buffer-role status.
// No backpressure: the display pulls with rd_en, and the shifter pushes one pixel per clock.
interface mo_line_buffer_if #(
  parameter int XW   = 9,
  parameter int PW   = 8,
  parameter int NBUF = 2
);
  localparam int BW = mo_lb_pkg::idx_w(NBUF);

  logic          swap;
  logic          wr_ld;
  logic [XW-1:0] wr_x;
  logic          wr_valid;
  logic [PW-1:0] wr_pix;
  logic          rd_en;
  logic [PW-1:0] rd_pix;
  logic          rd_valid;
  logic [BW-1:0] wr_buf;
  logic [BW-1:0] rd_buf;

  modport master (
    output swap, wr_ld, wr_x, wr_valid, wr_pix, rd_en,
    input  rd_pix, rd_valid, wr_buf, rd_buf
  );

  modport slave (
    input  swap, wr_ld, wr_x, wr_valid, wr_pix, rd_en,
    output rd_pix, rd_valid, wr_buf, rd_buf
  );
endinterface

// File: rtl/mo_lb_bank.sv
// One 2**XW x PW line buffer: a synchronous read port with a one-cycle registered output, plus one write port.
// A read and a write to the same address in the same cycle return the old contents. Contents are never reset.
module mo_lb_bank #(
  parameter int XW = 9,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [XW-1:0] rd_addr,
  output logic [PW-1:0] rd_dat,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_addr,
  input  logic [PW-1:0] wr_dat
);
  logic [PW-1:0] mem [2**XW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end
endmodule

// File: rtl/mo_line_buffer.sv
// Rotating motion-object line buffers: write commits 1 cycle (last-wins) or 2 cycles (first-wins RMW) after the pixel.
// Display read latency is 1 cycle. No backpressure: one pixel per clock is sustained on each side.
module mo_line_buffer
  import mo_lb_pkg::*;
#(
  parameter int XW        = 9,
  parameter int PW        = 8,
  parameter int NBUF      = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic             clk,
  input  logic             reset_b,
  mo_line_buffer_if.slave  bus
);
  localparam int            BW       = idx_w(NBUF);
  localparam bit            FIRST    = (PRIO_MODE == int'(PRIO_FIRST));
  localparam logic [BW-1:0] LAST_BUF = BW'(NBUF - 1);

  if (NBUF < 2) begin : g_bad_nbuf
    $error("mo_line_buffer: NBUF must be at least 2");
  end

  logic [BW-1:0] wr_buf, rd_buf, rd_sel;
  logic [XW-1:0] wr_cnt, rd_cnt, wr_addr;
  logic          primed, rd_valid_q, wr_hit;

  logic          s1_vld, lw_vld, s2_commit;
  logic [XW-1:0] s1_addr, lw_addr;
  logic [PW-1:0] s1_pix, lw_pix, s1_cell;
  logic [BW-1:0] s1_buf, lw_buf;

  logic          cm_vld;
  logic [BW-1:0] cm_buf;
  logic [XW-1:0] cm_addr;
  logic [PW-1:0] cm_pix;

  logic          bank_re    [NBUF];
  logic [XW-1:0] bank_raddr [NBUF];
  logic [PW-1:0] bank_q     [NBUF];
  logic          bank_we    [NBUF];
  logic [XW-1:0] bank_waddr [NBUF];
  logic [PW-1:0] bank_wdat  [NBUF];

  assign wr_addr = bus.wr_ld ? bus.wr_x : wr_cnt;
  assign wr_hit  = bus.wr_valid && (bus.wr_pix != PW'(TRANSPARENT));

  // The cell read in stage 1 is stale if the previous cycle committed to it.
  always_comb begin
    s1_cell   = (lw_vld && lw_addr == s1_addr && lw_buf == s1_buf) ? lw_pix : bank_q[s1_buf];
    s2_commit = FIRST && s1_vld && (s1_cell == PW'(TRANSPARENT));
    cm_vld    = FIRST ? s2_commit : wr_hit;
    cm_buf    = FIRST ? s1_buf    : wr_buf;
    cm_addr   = FIRST ? s1_addr   : wr_addr;
    cm_pix    = FIRST ? s1_pix    : bus.wr_pix;
  end

  // Steer each bank by role. A late first-wins commit right after swap owns the write port.
  always_comb begin
    for (int b = 0; b < NBUF; b++) begin
      bank_re[b]    = (bus.rd_en && rd_buf == BW'(b)) || (FIRST && wr_hit && wr_buf == BW'(b));
      bank_raddr[b] = (rd_buf == BW'(b)) ? rd_cnt : wr_addr;
      bank_we[b]    = (cm_vld && cm_buf == BW'(b)) || (bus.rd_en && rd_buf == BW'(b));
      bank_waddr[b] = (cm_vld && cm_buf == BW'(b)) ? cm_addr : rd_cnt;
      bank_wdat[b]  = (cm_vld && cm_buf == BW'(b)) ? cm_pix : '0;
    end
  end

  for (genvar g = 0; g < NBUF; g++) begin : g_bank
    mo_lb_bank #(.XW(XW), .PW(PW)) u_bank (
      .clk     (clk),
      .rd_en   (bank_re[g]),
      .rd_addr (bank_raddr[g]),
      .rd_dat  (bank_q[g]),
      .wr_en   (bank_we[g]),
      .wr_addr (bank_waddr[g]),
      .wr_dat  (bank_wdat[g])
    );
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_buf     <= '0;
      rd_buf     <= LAST_BUF;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      primed     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sel     <= '0;
      s1_vld     <= 1'b0;
      s1_addr    <= '0;
      s1_pix     <= '0;
      s1_buf     <= '0;
      lw_vld     <= 1'b0;
      lw_addr    <= '0;
      lw_pix     <= '0;
      lw_buf     <= '0;
    end else begin
      if (bus.swap) begin
        wr_buf <= (wr_buf == LAST_BUF) ? '0 : wr_buf + 1'b1;
        rd_buf <= wr_buf;
        primed <= 1'b1;
      end
      if (bus.wr_ld)         wr_cnt <= bus.wr_valid ? bus.wr_x + 1'b1 : bus.wr_x;
      else if (bus.wr_valid) wr_cnt <= wr_cnt + 1'b1;
      if (bus.swap)          rd_cnt <= '0;
      else if (bus.rd_en)    rd_cnt <= rd_cnt + 1'b1;
      rd_valid_q <= bus.rd_en && primed;
      if (bus.rd_en) rd_sel <= rd_buf;
      s1_vld  <= FIRST && wr_hit;
      s1_addr <= wr_addr;
      s1_pix  <= bus.wr_pix;
      s1_buf  <= wr_buf;
      lw_vld  <= s2_commit;
      lw_addr <= s1_addr;
      lw_pix  <= s1_pix;
      lw_buf  <= s1_buf;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_pix   = rd_valid_q ? bank_q[rd_sel] : '0;
  assign bus.wr_buf   = wr_buf;
  assign bus.rd_buf   = rd_buf;
endmodule

// File: tb/tb_mo_line_buffer.sv
// Directed bench: three instances (NBUF=2 last-wins, NBUF=2 first-wins, NBUF=3 last-wins) share one stimulus stream.
module tb_mo_line_buffer;
  localparam int XW    = 9;
  localparam int PW    = 8;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          swap = 1'b0, wr_ld = 1'b0, wr_valid = 1'b0, rd_en = 1'b0;
  logic [XW-1:0] wr_x = '0;
  logic [PW-1:0] wr_pix = '0;

  int checks = 0;
  int errors = 0;
  int rv_bad;
  int nz0, nz1;
  logic [PW-1:0] got0 [DEPTH];
  logic [PW-1:0] got1 [DEPTH];
  logic [PW-1:0] got3 [DEPTH];

  typedef struct {
    bit s; bit ld; int x; bit v; int p; bit r;
    int wb0; int rb0; int wb3; int rb3; bit rv; int pix;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  mo_line_buffer_if #(.XW(XW), .PW(PW), .NBUF(2)) if0 ();
  mo_line_buffer_if #(.XW(XW), .PW(PW), .NBUF(2)) if1 ();
  mo_line_buffer_if #(.XW(XW), .PW(PW), .NBUF(3)) if3 ();

  assign if0.swap = swap;  assign if0.wr_ld = wr_ld;  assign if0.wr_x = wr_x;
  assign if0.wr_valid = wr_valid;  assign if0.wr_pix = wr_pix;  assign if0.rd_en = rd_en;
  assign if1.swap = swap;  assign if1.wr_ld = wr_ld;  assign if1.wr_x = wr_x;
  assign if1.wr_valid = wr_valid;  assign if1.wr_pix = wr_pix;  assign if1.rd_en = rd_en;
  assign if3.swap = swap;  assign if3.wr_ld = wr_ld;  assign if3.wr_x = wr_x;
  assign if3.wr_valid = wr_valid;  assign if3.wr_pix = wr_pix;  assign if3.rd_en = rd_en;

  mo_line_buffer #(.XW(XW), .PW(PW), .NBUF(2), .PRIO_MODE(0)) u_d0 (
    .clk(clk), .reset_b(reset_b), .bus(if0.slave));
  mo_line_buffer #(.XW(XW), .PW(PW), .NBUF(2), .PRIO_MODE(1)) u_d1 (
    .clk(clk), .reset_b(reset_b), .bus(if1.slave));
  mo_line_buffer #(.XW(XW), .PW(PW), .NBUF(3), .PRIO_MODE(0)) u_d3 (
    .clk(clk), .reset_b(reset_b), .bus(if3.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit ld, input int x, input bit v, input int p, input bit r);
    swap = s; wr_ld = ld; wr_x = XW'(x); wr_valid = v; wr_pix = PW'(p); rd_en = r;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic wr(input bit ld, input int x, input int p);
    drive(0, ld, x, 1, p, 0);
    tick();
  endtask

  task automatic do_swap();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_line(input int start, input int n);
    rv_bad = 0;
    for (int a = 0; a < n; a++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick();
      got0[(start + a) % DEPTH] = if0.rd_pix;
      got1[(start + a) % DEPTH] = if1.rd_pix;
      got3[(start + a) % DEPTH] = if3.rd_pix;
      if (!(if0.rd_valid && if1.rd_valid && if3.rd_valid)) rv_bad++;
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    vt[0] = '{1, 0,  0, 0, 0, 0,  1, 0, 1, 0, 0, 0};
    vt[1] = '{1, 0,  0, 0, 0, 0,  0, 1, 2, 1, 0, 0};
    vt[2] = '{0, 1, 10, 1, 5, 0,  0, 1, 2, 1, 0, 0};
    vt[3] = '{0, 0,  0, 1, 0, 0,  0, 1, 2, 1, 0, 0};
    vt[4] = '{0, 0,  0, 1, 7, 0,  0, 1, 2, 1, 0, 0};
    vt[5] = '{0, 0,  0, 0, 0, 0,  0, 1, 2, 1, 0, 0};
    vt[6] = '{1, 0,  0, 0, 0, 0,  1, 0, 0, 2, 0, 0};
    vt[7] = '{0, 0,  0, 0, 0, 1,  1, 0, 0, 2, 1, 0};

    // Scrub every buffer through the clear-behind-read path, then reset again.
    repeat (3) tick();
    reset_b = 1'b1;
    read_line(0, DEPTH);
    do_swap();
    read_line(0, DEPTH);
    do_swap();
    read_line(0, DEPTH);

    reset_b = 1'b0;
    #1;
    chk("rst_wb0", 32'(if0.wr_buf), 0);
    chk("rst_rb0", 32'(if0.rd_buf), 1);
    chk("rst_rv0", 32'(if0.rd_valid), 0);
    chk("rst_pix0", 32'(if0.rd_pix), 0);
    chk("rst_rb3", 32'(if3.rd_buf), 2);
    tick();
    reset_b = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].s, vt[i].ld, vt[i].x, vt[i].v, vt[i].p, vt[i].r);
      tick();
      chk($sformatf("vec%0d_wb0", i), 32'(if0.wr_buf), 32'(vt[i].wb0));
      chk($sformatf("vec%0d_rb0", i), 32'(if0.rd_buf), 32'(vt[i].rb0));
      chk($sformatf("vec%0d_wb3", i), 32'(if3.wr_buf), 32'(vt[i].wb3));
      chk($sformatf("vec%0d_rb3", i), 32'(if3.rd_buf), 32'(vt[i].rb3));
      chk($sformatf("vec%0d_rv0", i), 32'(if0.rd_valid), 32'(vt[i].rv));
      chk($sformatf("vec%0d_rv3", i), 32'(if3.rd_valid), 32'(vt[i].rv));
      chk($sformatf("vec%0d_pix0", i), 32'(if0.rd_pix), 32'(vt[i].pix));
    end

    read_line(1, DEPTH - 1);
    chk("basic_rv", 32'(rv_bad), 0);
    chk("basic_d0_x10", 32'(got0[10]), 5);
    chk("basic_d0_x11", 32'(got0[11]), 0);
    chk("basic_d0_x12", 32'(got0[12]), 7);
    chk("basic_d1_x10", 32'(got1[10]), 5);
    chk("basic_d1_x12", 32'(got1[12]), 7);
    chk("basic_d3_x10", 32'(got3[10]), 5);
    chk("basic_d3_x12", 32'(got3[12]), 7);

    do_swap();
    do_swap();
    read_line(0, DEPTH);
    nz0 = 0;
    nz1 = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (got0[a] != 0) nz0++;
      if (got1[a] != 0) nz1++;
    end
    chk("cleared_d0_nonzero", 32'(nz0), 0);
    chk("cleared_d1_nonzero", 32'(nz1), 0);

    wr(1, 510, 1);
    wr(0, 0, 2);
    wr(0, 0, 3);
    wr(0, 0, 4);
    idle();
    idle();
    do_swap();
    read_line(0, DEPTH);
    chk("wrap_d0_510", 32'(got0[510]), 1);
    chk("wrap_d0_511", 32'(got0[511]), 2);
    chk("wrap_d0_0", 32'(got0[0]), 3);
    chk("wrap_d0_1", 32'(got0[1]), 4);
    chk("wrap_d1_0", 32'(got1[0]), 3);
    chk("wrap_d3_511", 32'(got3[511]), 2);

    // Spaced overlap at x=20, back-to-back overlap at x=40 exercises forwarding.
    wr(1, 20, 3);
    idle();
    idle();
    idle();
    wr(1, 20, 9);
    idle();
    wr(1, 40, 3);
    wr(1, 40, 9);
    idle();
    idle();
    do_swap();
    read_line(0, DEPTH);
    chk("ovl_last_x20", 32'(got0[20]), 9);
    chk("ovl_last_x40", 32'(got0[40]), 9);
    chk("ovl_first_x20", 32'(got1[20]), 3);
    chk("ovl_first_x40_fwd", 32'(got1[40]), 3);
    chk("ovl_n3_x40", 32'(got3[40]), 9);

    wr(1, 3, 8);
    idle();
    idle();
    do_swap();
    for (int a = 0; a < 3; a++) begin
      drive(0, 0, 0, 0, 0, 1);
      tick();
    end
    drive(1, 1, 0, 1, 11, 1);
    tick();
    chk("coll_rd_d0", 32'(if0.rd_pix), 8);
    chk("coll_rd_d1", 32'(if1.rd_pix), 8);
    chk("coll_rd_d3", 32'(if3.rd_pix), 8);
    chk("coll_wb0", 32'(if0.wr_buf), 1);
    chk("coll_rb0", 32'(if0.rd_buf), 0);
    chk("coll_wb3", 32'(if3.wr_buf), 0);
    chk("coll_rb3", 32'(if3.rd_buf), 2);
    idle();
    read_line(0, DEPTH);
    chk("coll_land_d0", 32'(got0[0]), 11);
    chk("coll_land_d1", 32'(got1[0]), 11);
    chk("coll_land_d3", 32'(got3[0]), 11);

    do_swap();
    chk("mid_pre_wb3", 32'(if3.wr_buf), 1);
    drive(0, 0, 0, 1, 5, 1);
    tick();
    chk("mid_pre_rv3", 32'(if3.rd_valid), 1);
    reset_b = 1'b0;
    #1;
    chk("mid_rst_rv3", 32'(if3.rd_valid), 0);
    chk("mid_rst_wb3", 32'(if3.wr_buf), 0);
    chk("mid_rst_rb3", 32'(if3.rd_buf), 2);
    chk("mid_rst_rb0", 32'(if0.rd_buf), 1);
    chk("mid_rst_pix3", 32'(if3.rd_pix), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
